// File: rtl/pcileech_pcie_rst_seq.sv
// pcileech_pcie_rst_seq
// PCIe reset sequencer for the 75T-484 x1 boards. PERST# and link-up are
// synchronized, PERST# release is debounced, then the core reset is held for
// a fixed window before waiting for the link to train.
//
// Optional feature macro: PCILEECH_RST_LINK_WATCHDOG_EN
//   defined   : WAIT_LINK times out, re-pulses reset up to PARAM_MAX_RETRY
//               times, then parks in FAIL with link_fail set.
//   undefined : WAIT_LINK waits forever; retry_cnt and link_fail stay 0.
module pcileech_pcie_rst_seq #(
  parameter logic [15:0] PARAM_DEBOUNCE_CYCLES = 16'd1024,
  parameter logic [15:0] PARAM_HOLD_CYCLES     = 16'd16,
  parameter logic [31:0] PARAM_LINK_TIMEOUT    = 32'd100_000_000,
  parameter logic [1:0]  PARAM_MAX_RETRY       = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pcie_perst_n,
  input  logic       pcie_lnk_up,
  output logic       pcie_reset,
  output logic       ready,
  output logic       link_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_HOLD      = 3'd2,
    ST_WAIT_LINK = 3'd3,
    ST_UP        = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // Terminal counts, compared against the zero-extended 32-bit counter.
  localparam logic [31:0] DEB_LAST  = {16'd0, PARAM_DEBOUNCE_CYCLES} - 32'd1;
  localparam logic [31:0] HOLD_LAST = {16'd0, PARAM_HOLD_CYCLES} - 32'd1;
`ifdef PCILEECH_RST_LINK_WATCHDOG_EN
  localparam logic [31:0] LINK_LAST = PARAM_LINK_TIMEOUT - 32'd1;
`else
  // Timeout/retry parameters have no effect without the watchdog.
  logic unused_cfg;
  assign unused_cfg = ^{PARAM_LINK_TIMEOUT, PARAM_MAX_RETRY};
`endif

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  retry_d;
  logic        fail_d;

  logic perst_p0, perst_s;
  logic lnk_p0, lnk_s;

  // Stage p0 -> s: two-flop synchronizers for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perst_p0 <= 1'b0;
      perst_s  <= 1'b0;
      lnk_p0   <= 1'b0;
      lnk_s    <= 1'b0;
    end else begin
      perst_p0 <= pcie_perst_n;
      perst_s  <= perst_p0;
      lnk_p0   <= pcie_lnk_up;
      lnk_s    <= lnk_p0;
    end
  end

  // Next-state, counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    fail_d  = link_fail;
    if ((state_q != ST_RESET) && !perst_s) begin
      // PERST# re-asserted: restart from RESET, clearing its bookkeeping on
      // entry so the status outputs are clean on the same edge.
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          cnt_d   = '0;
          retry_d = '0;
          fail_d  = 1'b0;
          if (perst_s) state_d = ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LINK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_WAIT_LINK: begin
          if (lnk_s) begin
            // Link-up wins over a coincident timeout.
            state_d = ST_UP;
            cnt_d   = '0;
          end
`ifdef PCILEECH_RST_LINK_WATCHDOG_EN
          else if (cnt_q == LINK_LAST) begin
            cnt_d = '0;
            if (retry_cnt < PARAM_MAX_RETRY) begin
              retry_d = retry_cnt + 2'd1;
              state_d = ST_HOLD;
            end else begin
              fail_d  = 1'b1;
              state_d = ST_FAIL;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
`endif
        end
        ST_UP: begin
          if (!lnk_s) begin
            state_d = ST_WAIT_LINK;
            cnt_d   = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end
`ifndef PCILEECH_RST_LINK_WATCHDOG_EN
    retry_d = '0;
    fail_d  = 1'b0;
`endif
  end

  // State register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs decoded from the next state, so they move on the
  // same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcie_reset <= 1'b1;
      ready      <= 1'b0;
      link_fail  <= 1'b0;
      retry_cnt  <= '0;
      seq_state  <= ST_RESET;
    end else begin
      pcie_reset <= (state_d == ST_RESET) || (state_d == ST_DEBOUNCE) ||
                    (state_d == ST_HOLD);
      ready      <= (state_d == ST_UP);
      link_fail  <= fail_d;
      retry_cnt  <= retry_d;
      seq_state  <= state_d;
    end
  end

endmodule

// File: tb/tb_pcileech_pcie_rst_seq.sv
// Bench for pcileech_pcie_rst_seq with DEBOUNCE=4, HOLD=8, TIMEOUT=64,
// MAX_RETRY=2. Expected output vectors are queued per cycle by the stimulus
// and consumed by an independent monitor on the falling edge.
module tb_pcileech_pcie_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pcie_perst_n = 1'b0;
  logic       pcie_lnk_up = 1'b0;
  logic       pcie_reset, ready, link_fail;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  pcileech_pcie_rst_seq #(
    .PARAM_DEBOUNCE_CYCLES(16'd4),
    .PARAM_HOLD_CYCLES(16'd8),
    .PARAM_LINK_TIMEOUT(32'd64),
    .PARAM_MAX_RETRY(2'd2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pcie_perst_n(pcie_perst_n),
    .pcie_lnk_up(pcie_lnk_up),
    .pcie_reset(pcie_reset),
    .ready(ready),
    .link_fail(link_fail),
    .retry_cnt(retry_cnt),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic probe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Vector layout: {pcie_reset, ready, link_fail, retry_cnt[1:0], seq_state[2:0]}
  function automatic logic [7:0] v(input logic r, input logic rd, input logic lf,
                                   input logic [1:0] rc, input logic [2:0] st);
    return {r, rd, lf, rc, st};
  endfunction

  function automatic logic [7:0] hold_v(input logic [1:0] rc);
    return v(1'b1, 1'b0, 1'b0, rc, 3'd2);
  endfunction
  function automatic logic [7:0] wl_v(input logic [1:0] rc);
    return v(1'b0, 1'b0, 1'b0, rc, 3'd3);
  endfunction
  function automatic logic [7:0] up_v(input logic [1:0] rc);
    return v(1'b0, 1'b1, 1'b0, rc, 3'd4);
  endfunction

  logic [7:0] rst_vec, deb_vec, fail_vec;
  initial begin
    rst_vec  = v(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
    deb_vec  = v(1'b1, 1'b0, 1'b0, 2'd0, 3'd1);
    fail_vec = v(1'b0, 1'b0, 1'b1, 2'd2, 3'd5);
  end

  task automatic expect_at(input int c, input logic [7:0] e, input string nm);
    exp_t t;
    t.cyc = c;
    t.exp = e;
    t.nm  = nm;
    q.push_back(t);
  endtask

  task automatic expect_span(input int c0, input int c1, input logic [7:0] e,
                             input string nm);
    for (int i = c0; i <= c1; i++) expect_at(i, e, nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input exp_t e, input logic [7:0] a);
    checks++;
    if (a !== e.exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got rst=%0b rdy=%0b lf=%0b rc=%0d st=%0d want rst=%0b rdy=%0b lf=%0b rc=%0d st=%0d",
               e.nm, e.cyc, a[7], a[6], a[5], a[4:3], a[2:0],
               e.exp[7], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
    end
  endtask

  // Monitor: consumes queued expectations on the falling edge, and the
  // asynchronous queue whenever the stimulus raises probe between edges.
  always @(negedge clk or posedge probe) begin : mon
    exp_t e;
    if (probe) begin
      while (aq.size() > 0) begin
        e = aq.pop_front();
        cmp(e, {pcie_reset, ready, link_fail, retry_cnt, seq_state});
      end
    end else begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s stale expectation cyc=%0d seen at cyc=%0d", e.nm, e.cyc, cyc);
        end else begin
          cmp(e, {pcie_reset, ready, link_fail, retry_cnt, seq_state});
        end
      end
    end
  end

  initial begin : stim
    int c0, c1, c2, g0, w, a0;
`ifdef PCILEECH_RST_LINK_WATCHDOG_EN
    int f0, s0;
`endif
    #1 rst_n = 1'b0;
    step(2);
    expect_at(cyc, rst_vec, "reset_state");
    rst_n = 1'b1;
    step(2);
    expect_span(cyc, cyc + 2, rst_vec, "idle_perst_low");
    step(3);

    // Clean release, link-up 20 cycles later, then link drop and PERST#.
    c0 = cyc;
    pcie_perst_n = 1'b1;
    expect_span(c0 + 1,  c0 + 2,  rst_vec,    "rel_sync");
    expect_span(c0 + 3,  c0 + 6,  deb_vec,    "rel_debounce");
    expect_span(c0 + 7,  c0 + 14, hold_v(0),  "rel_hold");
    expect_span(c0 + 15, c0 + 22, wl_v(0),    "rel_wait_link");
    expect_span(c0 + 23, c0 + 25, up_v(0),    "rel_up");
    step(20);
    pcie_lnk_up = 1'b1;
    step(6);
    c1 = cyc;
    pcie_lnk_up = 1'b0;
    expect_span(c1 + 1, c1 + 2, up_v(0), "drop_up_sync");
    expect_span(c1 + 3, c1 + 5, wl_v(0), "drop_wait_link");
    step(6);
    c2 = cyc;
    pcie_perst_n = 1'b0;
    expect_span(c2 + 1, c2 + 2, wl_v(0), "perst_sync");
    expect_span(c2 + 3, c2 + 5, rst_vec, "perst_reset");
    step(6);

    // Glitch: high 2 cycles, low 1, high again.
    g0 = cyc;
    pcie_perst_n = 1'b1;
    expect_span(g0 + 1,  g0 + 2,  rst_vec,   "glitch_sync");
    expect_span(g0 + 3,  g0 + 4,  deb_vec,   "glitch_deb_first");
    expect_at  (g0 + 5,           rst_vec,   "glitch_back_reset");
    expect_span(g0 + 6,  g0 + 9,  deb_vec,   "glitch_deb_second");
    expect_span(g0 + 10, g0 + 17, hold_v(0), "glitch_hold");
    expect_at  (g0 + 18,          wl_v(0),   "glitch_release");
    step(2);
    pcie_perst_n = 1'b0;
    step(1);
    pcie_perst_n = 1'b1;
    step(15);
    w = cyc;

`ifdef PCILEECH_RST_LINK_WATCHDOG_EN
    // Watchdog exhaustion with the link held low.
    expect_span(w + 1,   w + 63,  wl_v(0),   "wd_wait0");
    expect_span(w + 64,  w + 71,  hold_v(1), "wd_hold1");
    expect_span(w + 72,  w + 135, wl_v(1),   "wd_wait1");
    expect_span(w + 136, w + 143, hold_v(2), "wd_hold2");
    expect_span(w + 144, w + 207, wl_v(2),   "wd_wait2");
    expect_span(w + 208, w + 212, fail_vec,  "wd_fail");
    step(212);
    f0 = cyc;
    pcie_perst_n = 1'b0;
    expect_span(f0 + 1, f0 + 2, fail_vec, "fail_sync");
    expect_span(f0 + 3, f0 + 5, rst_vec,  "fail_perst_reset");
    step(6);

    // One retry, then link-up coinciding with the second timeout.
    s0 = cyc;
    pcie_perst_n = 1'b1;
    expect_span(s0 + 1,   s0 + 2,   rst_vec,   "sim_sync");
    expect_span(s0 + 3,   s0 + 6,   deb_vec,   "sim_debounce");
    expect_span(s0 + 7,   s0 + 14,  hold_v(0), "sim_hold0");
    expect_span(s0 + 15,  s0 + 78,  wl_v(0),   "sim_wait0");
    expect_span(s0 + 79,  s0 + 86,  hold_v(1), "sim_hold1");
    expect_span(s0 + 87,  s0 + 150, wl_v(1),   "sim_wait1");
    expect_span(s0 + 151, s0 + 155, up_v(1),   "sim_up");
    step(148);
    pcie_lnk_up = 1'b1;
    step(5);
    c1 = cyc;
    pcie_lnk_up = 1'b0;
    expect_span(c1 + 3, c1 + 4, wl_v(1), "sim_drop_keep_retry");
    step(5);
    c2 = cyc;
    pcie_perst_n = 1'b0;
    expect_span(c2 + 1, c2 + 2, wl_v(1), "sim_perst_sync");
    expect_span(c2 + 3, c2 + 4, rst_vec, "sim_perst_clear");
    step(5);
`else
    // No watchdog: WAIT_LINK persists with the link low.
    expect_span(w + 1, w + 1000, wl_v(0), "nowd_wait");
    step(1000);
    c2 = cyc;
    pcie_perst_n = 1'b0;
    expect_span(c2 + 1, c2 + 2, wl_v(0), "nowd_perst_sync");
    expect_span(c2 + 3, c2 + 4, rst_vec, "nowd_perst_reset");
    step(5);
`endif

    // Asynchronous reset in the middle of WAIT_LINK.
    a0 = cyc;
    pcie_perst_n = 1'b1;
    expect_span(a0 + 1,  a0 + 2,  rst_vec,   "async_pre_sync");
    expect_span(a0 + 3,  a0 + 6,  deb_vec,   "async_pre_deb");
    expect_span(a0 + 7,  a0 + 14, hold_v(0), "async_pre_hold");
    expect_span(a0 + 15, a0 + 19, wl_v(0),   "async_pre_wait");
    step(20);
    rst_n = 1'b0;
    #1;
    begin
      exp_t t;
      t.cyc = -1;
      t.exp = rst_vec;
      t.nm  = "async_reset_no_edge";
      aq.push_back(t);
    end
    probe = 1'b1;
    #1 probe = 1'b0;
    expect_at(cyc, rst_vec, "async_reset_held");
    step(1);
    rst_n = 1'b1;
    expect_span(a0 + 21, a0 + 23, rst_vec,   "async_resync");
    expect_span(a0 + 24, a0 + 27, deb_vec,   "async_redebounce");
    expect_span(a0 + 28, a0 + 29, hold_v(0), "async_rehold");
    step(10);

    checks++;
    if (q.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d/%0d pending want 0/0", q.size(), aq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : timeout
    #200000;
    $display("FAIL timeout got no completion want finish before 200000ns");
    $fatal(1, "bench timeout");
  end

endmodule
